sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_pkg.sv | 40 ++++
 rtl/sprite_axis_step.sv | 44 ++++
 rtl/sprite_mover.sv | 171 +++++++++++++++++
 tb/tb_sprite_mover.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, key map and widths for the sprite mover
package sprite_pkg;

   localparam int CW = 10;

   typedef enum logic [2:0] {
      DIR_IDLE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_t;

   localparam logic [7:0] KEY_RECENTER = 8'h72;

   // Rows are players 0..3, columns are up/left/down/right.
   localparam logic [7:0] KEY_MAP [4][4] = '{
      '{8'h77, 8'h61, 8'h73, 8'h64},
      '{8'h69, 8'h6A, 8'h6B, 8'h6C},
      '{8'h74, 8'h66, 8'h67, 8'h68},
      '{8'h38, 8'h34, 8'h35, 8'h36}
   };

   function automatic dir_t key_dir(input logic [1:0] col);
      case (col)
         2'd0:    return DIR_UP;
         2'd1:    return DIR_LEFT;
         2'd2:    return DIR_DOWN;
         default: return DIR_RIGHT;
      endcase
   endfunction

   function automatic dir_t dir_decode(input logic [2:0] code);
      if (code > 3'd4) begin
         return DIR_IDLE;
      end
      return dir_t'(code);
   endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// rtl/sprite_axis_step.sv - one-axis coordinate step with clamp or wrap at the edges
module sprite_axis_step
   import sprite_pkg::*;
#(
   parameter int MAX  = 639,
   parameter int STEP = 4,
   parameter int WRAP = 0
) (
   input  logic [CW-1:0] pos_i,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] pos_o
);

   localparam logic [CW:0] MAX_W  = (CW+1)'(MAX);
   localparam logic [CW:0] STEP_W = (CW+1)'(STEP);
   localparam logic [CW:0] SPAN_W = (CW+1)'(MAX + 1);

   logic [CW:0]   pos_w;
   logic [CW:0]   sum_w;
   logic [CW-1:0] res_w;

   // 11-bit intermediates keep pos+STEP and pos+SPAN-STEP free of overflow.
   always_comb begin
      pos_w = {1'b0, pos_i};
      sum_w = pos_w + STEP_W;
      res_w = pos_i;
      if (inc_i) begin
         if (sum_w > MAX_W) begin
            res_w = (WRAP != 0) ? CW'(sum_w - SPAN_W) : CW'(MAX_W);
         end else begin
            res_w = CW'(sum_w);
         end
      end else if (dec_i) begin
         if (pos_w < STEP_W) begin
            res_w = (WRAP != 0) ? CW'(pos_w + SPAN_W - STEP_W) : '0;
         end else begin
            res_w = CW'(pos_w - STEP_W);
         end
      end
      pos_o = res_w;
   end

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - keyboard-driven movement of up to four sprites with collision flag
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int N_PLAYERS = 2,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479,
   parameter int STEP      = 4,
   parameter int WRAP      = 0,
   parameter int HIT       = 16,
   parameter int X_INIT    = 320,
   parameter int Y_INIT    = 240
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_key_valid,
   input  logic [7:0]              i_key_ascii,
   input  logic                    i_break,
   input  logic                    i_frame_tick,
   output logic [N_PLAYERS*CW-1:0] o_x,
   output logic [N_PLAYERS*CW-1:0] o_y,
   output logic [N_PLAYERS*3-1:0]  o_state,
   output logic                    o_moved,
   output logic                    o_collide
);

   localparam logic [CW-1:0] X_RST = CW'(X_INIT);
   localparam logic [CW-1:0] Y_RST = CW'(Y_INIT);
   localparam logic [CW:0]   HIT_W = (CW+1)'(HIT);

   dir_t          state_q [N_PLAYERS];
   dir_t          state_d [N_PLAYERS];
   dir_t          dir_eff [N_PLAYERS];
   logic [CW-1:0] x_q     [N_PLAYERS];
   logic [CW-1:0] x_d     [N_PLAYERS];
   logic [CW-1:0] x_step  [N_PLAYERS];
   logic [CW-1:0] y_q     [N_PLAYERS];
   logic [CW-1:0] y_d     [N_PLAYERS];
   logic [CW-1:0] y_step  [N_PLAYERS];
   logic          moved_q;
   logic          moved_d;
   logic          collide_q;
   logic          collide_d;
   logic          recenter;

   assign recenter = i_key_valid && !i_break && (i_key_ascii == KEY_RECENTER);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            state_q[p] <= DIR_IDLE;
         end
      end else begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            state_q[p] <= state_d[p];
         end
      end
   end

   // Keys of players beyond N_PLAYERS are never compared, so they fall through unmapped.
   always_comb begin
      for (int p = 0; p < N_PLAYERS; p++) begin
         state_d[p] = dir_eff[p];
         if (recenter) begin
            state_d[p] = DIR_IDLE;
         end else if (i_key_valid) begin
            for (int k = 0; k < 4; k++) begin
               if (i_key_ascii == KEY_MAP[p][k]) begin
                  if (!i_break) begin
                     state_d[p] = key_dir(2'(k));
                  end else if (dir_eff[p] == key_dir(2'(k))) begin
                     state_d[p] = DIR_IDLE;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      o_state = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         dir_eff[p]         = dir_decode(state_q[p]);
         o_state[p*3 +: 3]  = dir_eff[p];
      end
   end

   // Steps use the pre-event state, so a key arriving with the tick only affects later ticks.
   for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
      sprite_axis_step #(
         .MAX  (X_MAX),
         .STEP (STEP),
         .WRAP (WRAP)
      ) u_x_step (
         .pos_i (x_q[p]),
         .inc_i (i_frame_tick && (dir_eff[p] == DIR_RIGHT)),
         .dec_i (i_frame_tick && (dir_eff[p] == DIR_LEFT)),
         .pos_o (x_step[p])
      );

      sprite_axis_step #(
         .MAX  (Y_MAX),
         .STEP (STEP),
         .WRAP (WRAP)
      ) u_y_step (
         .pos_i (y_q[p]),
         .inc_i (i_frame_tick && (dir_eff[p] == DIR_DOWN)),
         .dec_i (i_frame_tick && (dir_eff[p] == DIR_UP)),
         .pos_o (y_step[p])
      );

      assign o_x[p*CW +: CW] = x_q[p];
      assign o_y[p*CW +: CW] = y_q[p];
   end

   always_comb begin
      moved_d = 1'b0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         x_d[p] = recenter ? X_RST : x_step[p];
         y_d[p] = recenter ? Y_RST : y_step[p];
         if ((x_d[p] != x_q[p]) || (y_d[p] != y_q[p])) begin
            moved_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            x_q[p] <= X_RST;
            y_q[p] <= Y_RST;
         end
         moved_q <= 1'b0;
      end else begin
         for (int p = 0; p < N_PLAYERS; p++) begin
            x_q[p] <= x_d[p];
            y_q[p] <= y_d[p];
         end
         moved_q <= moved_d;
      end
   end

   function automatic logic near(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW-1:0] diff;
      diff = (a > b) ? (a - b) : (b - a);
      return {1'b0, diff} < HIT_W;
   endfunction

   always_comb begin
      collide_d = 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         for (int j = i + 1; j < N_PLAYERS; j++) begin
            if (near(x_q[i], x_q[j]) && near(y_q[i], y_q[j])) begin
               collide_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         collide_q <= 1'b0;
      end else begin
         collide_q <= collide_d;
      end
   end

   assign o_moved   = moved_q;
   assign o_collide = collide_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - directed self-checking bench for sprite_mover
module tb_sprite_mover;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       key_valid  = 1'b0;
   logic [7:0] key_ascii  = 8'h00;
   logic       brk        = 1'b0;
   logic       frame_tick = 1'b0;

   logic [19:0] x_a, y_a, x_c, y_c, x_w, y_w;
   logic [5:0]  st_a, st_c, st_w;
   logic        mv_a, mv_c, mv_w, co_a, co_c, co_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sprite_mover dut_a (
      .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_ascii(key_ascii),
      .i_break(brk), .i_frame_tick(frame_tick),
      .o_x(x_a), .o_y(y_a), .o_state(st_a), .o_moved(mv_a), .o_collide(co_a)
   );

   sprite_mover #(.X_INIT(2)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_ascii(key_ascii),
      .i_break(brk), .i_frame_tick(frame_tick),
      .o_x(x_c), .o_y(y_c), .o_state(st_c), .o_moved(mv_c), .o_collide(co_c)
   );

   sprite_mover #(.WRAP(1), .X_INIT(638)) dut_w (
      .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_ascii(key_ascii),
      .i_break(brk), .i_frame_tick(frame_tick),
      .o_x(x_w), .o_y(y_w), .o_state(st_w), .o_moved(mv_w), .o_collide(co_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic kv, input logic [7:0] a, input logic b, input logic tk);
      @(negedge clk);
      key_valid  = kv;
      key_ascii  = a;
      brk        = b;
      frame_tick = tk;
      @(posedge clk);
      #1;
      key_valid  = 1'b0;
      brk        = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic press(input logic [7:0] a);
      cycle(1'b1, a, 1'b0, 1'b0);
   endtask

   task automatic release_key(input logic [7:0] a);
      cycle(1'b1, a, 1'b1, 1'b0);
   endtask

   task automatic tick();
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_x", x_a, {10'd320, 10'd320});
      check("rst_y", y_a, {10'd240, 10'd240});
      check("rst_state", st_a, 0);
      check("rst_moved", mv_a, 0);
      check("rst_collide", co_a, 0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      check("collide_after_rst", co_a, 1);

      // P0 right, three ticks
      press(8'h64);
      check("d_state", st_a, 4);
      check("d_x_before_tick", x_a[9:0], 320);
      tick();
      check("d_x1", x_a[9:0], 324);
      check("d_moved1", mv_a, 1);
      check("wrap_x", x_w[9:0], 2);
      idle();
      check("moved_one_cycle", mv_a, 0);
      tick();
      check("d_x2", x_a[9:0], 328);
      tick();
      check("d_x3", x_a[9:0], 332);
      check("d_moved3", mv_a, 1);
      check("wrap_x3", x_w[9:0], 10);
      release_key(8'h64);
      check("d_release", st_a, 0);

      press(8'h72);
      check("r_x", x_a, {10'd320, 10'd320});
      check("r_moved", mv_a, 1);
      press(8'h72);
      check("r_again_moved", mv_a, 0);

      // Clamp at the left edge
      press(8'h61);
      tick();
      check("clamp_x0", x_c[9:0], 0);
      check("clamp_moved", mv_c, 1);
      tick();
      check("clamp_x0_hold", x_c[9:0], 0);
      check("clamp_no_moved", mv_c, 0);
      check("a_x", x_a[9:0], 312);
      release_key(8'h61);
      press(8'h72);

      press(8'h77);
      check("w_state", st_a[2:0], 1);
      press(8'h73);
      check("s_state", st_a[2:0], 2);
      release_key(8'h77);
      check("rel_w_ignored", st_a[2:0], 2);
      release_key(8'h73);
      check("rel_s_idle", st_a[2:0], 0);

      press(8'h38);
      check("p3_key_ignored", st_a, 0);
      press(8'h7a);
      check("unmapped_ignored", st_a, 0);
      tick();
      check("idle_tick_no_move", mv_a, 0);

      // Key together with a tick: move uses the old (IDLE) state
      cycle(1'b1, 8'h6c, 1'b0, 1'b1);
      check("l_tick_x1", x_a[19:10], 320);
      check("l_tick_moved", mv_a, 0);
      check("l_tick_state", st_a[5:3], 4);
      tick();
      check("l_next_x1", x_a[19:10], 324);
      check("l_next_moved", mv_a, 1);
      release_key(8'h6c);

      press(8'h64);
      cycle(1'b1, 8'h64, 1'b1, 1'b1);
      check("rel_tick_x0", x_a[9:0], 324);
      check("rel_tick_state", st_a[2:0], 0);

      press(8'h64);
      cycle(1'b1, 8'h72, 1'b0, 1'b1);
      check("r_tick_x", x_a, {10'd320, 10'd320});
      check("r_tick_state", st_a, 0);
      check("r_tick_moved", mv_a, 1);

      // Reset in the middle of a move
      press(8'h64);
      tick();
      check("pre_rst_x0", x_a[9:0], 324);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_x0", x_a[9:0], 320);
      check("async_rst_state", st_a, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post_rst_x0", x_a[9:0], 320);
      check("post_rst_moved", mv_a, 0);

      // Collision boundary on P1 moving away from P0
      press(8'h6c);
      tick();
      tick();
      release_key(8'h6c);
      press(8'h6b);
      tick();
      tick();
      release_key(8'h6b);
      check("p1_x", x_a[19:10], 328);
      check("p1_y", y_a[19:10], 248);
      idle();
      check("collide_near", co_a, 1);
      press(8'h6c);
      tick();
      idle();
      check("collide_12", co_a, 1);
      tick();
      check("p1_x_336", x_a[19:10], 336);
      check("collide_lag", co_a, 1);
      idle();
      check("collide_16_off", co_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
